// File: rtl/trace_line_streamer.sv
// Streams one captured trace string per request as "CCCC: <text>\n", one ASCII byte per
// out_val/out_rdy handshake, with a free-running 4-digit BCD cycle stamp.
module trace_line_streamer #(
  parameter int unsigned NCHARS    = 512,
  parameter int unsigned PREFIX_EN = 1,
  parameter int unsigned LENW      = $clog2(NCHARS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [NCHARS*8-1:0]   in_msg,
  input  logic [LENW-1:0]       in_len,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [7:0]            out_msg,
  output logic [15:0]           cycles
);

  typedef enum logic [1:0] {StIdle, StPrefix, StBody, StNl} state_e;

  state_e              state_q, state_d;
  logic [NCHARS*8-1:0] msg_q, msg_d;
  logic [LENW-1:0]     cnt_q, cnt_d;
  logic [15:0]         stamp_q, stamp_d;
  logic [2:0]          pre_q, pre_d;
  logic [15:0]         cycles_q;
  logic [LENW-1:0]     len_clamp;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] d, input logic blank);
    return blank ? 8'h20 : {4'h3, d};
  endfunction

  assign len_clamp = (in_len > LENW'(NCHARS)) ? LENW'(NCHARS) : in_len;
  assign cycles    = cycles_q;

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    cnt_d   = cnt_q;
    stamp_d = stamp_q;
    pre_d   = pre_q;
    in_rdy  = 1'b0;
    out_val = 1'b0;
    out_msg = 8'h00;
    unique case (state_q)
      StIdle: begin
        in_rdy = 1'b1;
        if (in_val) begin
          msg_d   = in_msg;
          cnt_d   = len_clamp;
          stamp_d = cycles_q;
          pre_d   = 3'd0;
          if (PREFIX_EN != 0)          state_d = StPrefix;
          else if (len_clamp == '0)    state_d = StNl;
          else                         state_d = StBody;
        end
      end
      StPrefix: begin
        out_val = 1'b1;
        // Leading zero digits blank out; the units digit always prints.
        case (pre_q)
          3'd0:    out_msg = digit_char(stamp_q[15:12], stamp_q[15:12] == 4'd0);
          3'd1:    out_msg = digit_char(stamp_q[11:8],  stamp_q[15:8]  == 8'd0);
          3'd2:    out_msg = digit_char(stamp_q[7:4],   stamp_q[15:4]  == 12'd0);
          3'd3:    out_msg = digit_char(stamp_q[3:0],   1'b0);
          3'd4:    out_msg = 8'h3A;
          default: out_msg = 8'h20;
        endcase
        if (out_rdy) begin
          if (pre_q == 3'd5) state_d = (cnt_q == '0) ? StNl : StBody;
          else               pre_d   = pre_q + 3'd1;
        end
      end
      StBody: begin
        out_val = 1'b1;
        out_msg = msg_q[NCHARS*8-1 -: 8];
        if (out_rdy) begin
          msg_d = msg_q << 8;
          cnt_d = cnt_q - LENW'(1);
          if (cnt_q == LENW'(1)) state_d = StNl;
        end
      end
      StNl: begin
        out_val = 1'b1;
        out_msg = 8'h0A;
        if (out_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      msg_q    <= '0;
      cnt_q    <= '0;
      stamp_q  <= '0;
      pre_q    <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      cnt_q    <= cnt_d;
      stamp_q  <= stamp_d;
      pre_q    <= pre_d;
      cycles_q <= bcd_inc(cycles_q);
    end
  end

endmodule

// File: tb/tb_trace_line_streamer.sv
// Directed bench: a prefixed 512-char instance and an 8-char prefix-less instance.
module tb_trace_line_streamer;

  localparam int unsigned NA  = 512;
  localparam int unsigned NB  = 8;
  localparam int unsigned LWA = $clog2(NA + 1);
  localparam int unsigned LWB = $clog2(NB + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic            in_val_a = 1'b0, in_rdy_a, out_val_a, out_rdy_a = 1'b1;
  logic [NA*8-1:0] in_msg_a = '0;
  logic [LWA-1:0]  in_len_a = '0;
  logic [7:0]      out_msg_a;
  logic [15:0]     cycles_a;

  logic            in_val_b = 1'b0, in_rdy_b, out_val_b, out_rdy_b = 1'b1;
  logic [NB*8-1:0] in_msg_b = '0;
  logic [LWB-1:0]  in_len_b = '0;
  logic [7:0]      out_msg_b;
  logic [15:0]     cycles_b;

  int errors = 0;
  int checks = 0;

  trace_line_streamer #(.NCHARS(NA), .PREFIX_EN(1)) dut_a (
    .clk(clk), .reset(reset), .in_val(in_val_a), .in_rdy(in_rdy_a), .in_msg(in_msg_a),
    .in_len(in_len_a), .out_val(out_val_a), .out_rdy(out_rdy_a), .out_msg(out_msg_a),
    .cycles(cycles_a)
  );

  trace_line_streamer #(.NCHARS(NB), .PREFIX_EN(0)) dut_b (
    .clk(clk), .reset(reset), .in_val(in_val_b), .in_rdy(in_rdy_b), .in_msg(in_msg_b),
    .in_len(in_len_b), .out_val(out_val_b), .out_rdy(out_rdy_b), .out_msg(out_msg_b),
    .cycles(cycles_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_val_a = 1'b0;
    in_val_b = 1'b0;
    out_rdy_a = 1'b1;
    out_rdy_b = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_cycles(input logic [15:0] target, input string tag);
    int n;
    n = 0;
    while (cycles_a !== target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(cycles_a), 32'(target));
  endtask

  // Drives one request at the current negedge and collects bytes until the newline.
  task automatic send_line(input bit sel, input int len, input string text, input string exp,
                           input bit tog, input string tag);
    logic [7:0] q[$];
    logic [7:0] held, m;
    logic       v, ir;
    bit         done, hold_ok, rdy_ok, bytes_ok, held_v, r;
    int         n;
    check({tag, " in_rdy before"}, 32'(sel ? in_rdy_b : in_rdy_a), 32'd1);
    if (sel) begin
      in_msg_b = '0;
      for (int i = 0; i < text.len() && i < NB; i++) in_msg_b[(NB-1-i)*8 +: 8] = text[i];
      in_len_b = LWB'(len);
      in_val_b = 1'b1;
    end else begin
      in_msg_a = '0;
      for (int i = 0; i < text.len() && i < NA; i++) in_msg_a[(NA-1-i)*8 +: 8] = text[i];
      in_len_a = LWA'(len);
      in_val_a = 1'b1;
    end
    @(posedge clk);
    #1;
    in_val_a = 1'b0;
    in_val_b = 1'b0;
    n = 0; done = 0; hold_ok = 1; rdy_ok = 1; held_v = 0; r = 1; held = 8'h00;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      r = tog ? ~r : 1'b1;
      if (sel) out_rdy_b = r; else out_rdy_a = r;
      v  = sel ? out_val_b : out_val_a;
      m  = sel ? out_msg_b : out_msg_a;
      ir = sel ? in_rdy_b : in_rdy_a;
      if (ir !== 1'b0) rdy_ok = 0;
      if (held_v && m !== held) hold_ok = 0;
      held_v = 0;
      if (v === 1'b1) begin
        if (r) begin
          q.push_back(m);
          if (m == 8'h0A) done = 1;
        end else begin
          held = m;
          held_v = 1;
        end
      end
    end
    check({tag, " line done"}, 32'(done), 32'd1);
    check({tag, " cycle count"}, 32'(n), 32'(tog ? 2 * exp.len() : exp.len()));
    check({tag, " byte count"}, 32'(q.size()), 32'(exp.len()));
    bytes_ok = (q.size() == exp.len());
    for (int i = 0; i < q.size() && i < exp.len(); i++) begin
      if (q[i] !== exp[i]) bytes_ok = 0;
    end
    check({tag, " bytes"}, 32'(bytes_ok), 32'd1);
    check({tag, " hold stable"}, 32'(hold_ok), 32'd1);
    check({tag, " in_rdy low"}, 32'(rdy_ok), 32'd1);
    @(negedge clk);
    out_rdy_a = 1'b1;
    out_rdy_b = 1'b1;
    check({tag, " in_rdy after"}, 32'(sel ? in_rdy_b : in_rdy_a), 32'd1);
    check({tag, " out_val after"}, 32'(sel ? out_val_b : out_val_a), 32'd0);
  endtask

  initial begin
    #12;
    check("rst in_rdy", 32'(in_rdy_a), 32'd1);
    check("rst out_val", 32'(out_val_a), 32'd0);
    check("rst out_msg", 32'(out_msg_a), 32'h00);
    check("rst cycles", 32'(cycles_a), 32'h0000);
    @(negedge clk);
    reset = 1'b1;

    wait_cycles(16'h0012, "t1 wait 12");
    send_line(0, 2, "ab", "  12: ab\n", 0, "t1");

    do_reset();
    wait_cycles(16'h0012, "t2 wait 12");
    send_line(0, 2, "ab", "  12: ab\n", 1, "t2");

    do_reset();
    send_line(0, 0, "", "   0: \n", 0, "t3a");
    send_line(1, 3, "xyz", "xyz\n", 0, "t3b");
    send_line(1, 13, "ABCDEFGH", "ABCDEFGH\n", 0, "t4 clamp");
    send_line(1, 0, "", "\n", 0, "t4 empty");

    do_reset();
    wait_cycles(16'h9999, "t5 reach 9999");
    @(negedge clk);
    check("t5 wrap", 32'(cycles_a), 32'h0000);
    wait_cycles(16'h0100, "t5 wait 100");
    send_line(0, 2, "hi", " 100: hi\n", 0, "t5 100");
    wait_cycles(16'h1234, "t5 wait 1234");
    send_line(0, 1, "Z", "1234: Z\n", 0, "t5 1234");

    do_reset();
    in_msg_a = '0;
    in_msg_a[NA*8-1 -: 16] = "qr";
    in_len_a = LWA'(2);
    in_val_a = 1'b1;
    out_rdy_a = 1'b1;
    @(posedge clk);
    #1;
    in_val_a = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t6 out_val", 32'(out_val_a), 32'd0);
    check("t6 out_msg", 32'(out_msg_a), 32'h00);
    check("t6 cycles", 32'(cycles_a), 32'h0000);
    check("t6 in_rdy", 32'(in_rdy_a), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    send_line(0, 2, "ok", "   0: ok\n", 0, "t6 after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
